vga_box_animator: RTL and testbench

Pixel-colour source sitting directly upstream of the VGA `display` controller. It takes the controller's pixel coordinates and produces the 3/3/3-bit RGB value for each pixel. The colour is a solid square that bounces around the 640x480 active area over a background colour. Its position updates once per frame, and its colour steps through an 8-entry palette on every wall bounce.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/box_axis.sv | 59 +++++
 rtl/vga_box_animator.sv | 106 ++++++++++
 tb/tb_vga_box_animator.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480 VGA constants, RGB type and the box animator palette.
// The timing constants are also used by the display controller.
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FRONT  = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BACK   = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FRONT  = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BACK   = 33;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [2:0] b;
   } rgb_t;

   localparam rgb_t BG_COLOR = 9'b000_000_001;

   typedef enum logic {ST_IDLE, ST_UPDATE} motion_st_t;

   function automatic rgb_t palette(input logic [2:0] idx);
      rgb_t c;
      case (idx)
         3'd0:    c = 9'b111_000_000;
         3'd1:    c = 9'b000_111_000;
         3'd2:    c = 9'b000_000_111;
         3'd3:    c = 9'b111_111_000;
         3'd4:    c = 9'b000_111_111;
         3'd5:    c = 9'b111_000_111;
         3'd6:    c = 9'b111_111_111;
         default: c = 9'b100_010_011;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/box_axis.sv
// One axis of the bouncing square: position, direction and wall-bounce detection.
// bounce_o is combinational and high only in the cycle upd_i is applied.
module box_axis #(
   parameter int LIMIT    = 640,
   parameter int BOX_SIZE = 32,
   parameter int STEP     = 2,
   parameter int POS0     = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       upd_i,
   output logic [9:0] pos_o,
   output logic       bounce_o
);

   logic [9:0]  pos_q, pos_d;
   logic        dir_q, dir_d;
   logic [10:0] pos_ext;

   assign pos_ext = {1'b0, pos_q};
   assign pos_o   = pos_q;

   // 11-bit compares so the far-wall test cannot wrap
   always_comb begin
      pos_d    = pos_q;
      dir_d    = dir_q;
      bounce_o = 1'b0;
      if (upd_i) begin
         if (dir_q) begin
            if (pos_ext + 11'(BOX_SIZE + STEP) > 11'(LIMIT)) begin
               pos_d    = 10'(LIMIT - BOX_SIZE);
               dir_d    = 1'b0;
               bounce_o = 1'b1;
            end else begin
               pos_d = pos_q + 10'(STEP);
            end
         end else begin
            if (pos_ext < 11'(STEP)) begin
               pos_d    = '0;
               dir_d    = 1'b1;
               bounce_o = 1'b1;
            end else begin
               pos_d = pos_q - 10'(STEP);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_q <= 10'(POS0);
         dir_q <= 1'b1;
      end else begin
         pos_q <= pos_d;
         dir_q <= dir_d;
      end
   end

endmodule

// File: rtl/vga_box_animator.sv
// Bouncing-square pixel source: per-frame motion, palette stepping on wall
// bounces, and a registered hit test producing RGB one pix_en after sampling.
module vga_box_animator
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int BOX_SIZE = 32,
   parameter int STEP     = 2,
   parameter int X0       = 0,
   parameter int Y0       = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_en,
   input  logic [9:0] hcount,
   input  logic [9:0] vcount,
   input  logic       video_on,
   input  logic       frame_tick,
   input  logic       freeze,
   output logic [2:0] red,
   output logic [2:0] green,
   output logic [2:0] blue,
   output logic [7:0] bounce_cnt
);

   motion_st_t  state_q, state_d;
   logic        upd;
   logic [9:0]  x, y;
   logic        bx, by;
   logic [2:0]  pal_q, pal_d;
   logic [7:0]  cnt_q, cnt_d;
   rgb_t        rgb_q, rgb_d;
   logic [10:0] h_ext, v_ext, x_ext, y_ext;
   logic        hit;

   box_axis #(.LIMIT(H_ACTIVE), .BOX_SIZE(BOX_SIZE), .STEP(STEP), .POS0(X0)) u_x (
      .clk(clk), .rst(rst), .upd_i(upd), .pos_o(x), .bounce_o(bx)
   );

   box_axis #(.LIMIT(V_ACTIVE), .BOX_SIZE(BOX_SIZE), .STEP(STEP), .POS0(Y0)) u_y (
      .clk(clk), .rst(rst), .upd_i(upd), .pos_o(y), .bounce_o(by)
   );

   // The move is applied on the accepting edge; UPDATE only swallows a
   // frame_tick that lingers into the following cycle.
   always_comb begin
      state_d = state_q;
      upd     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (frame_tick && !freeze) begin
               state_d = ST_UPDATE;
               upd     = 1'b1;
            end
         end
         ST_UPDATE: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pal_d = pal_q;
      cnt_d = cnt_q;
      if (bx || by) begin
         pal_d = pal_q + 3'd1;
         cnt_d = cnt_q + 8'd1;
      end
   end

   assign h_ext = {1'b0, hcount};
   assign v_ext = {1'b0, vcount};
   assign x_ext = {1'b0, x};
   assign y_ext = {1'b0, y};
   assign hit   = (h_ext >= x_ext) && (h_ext < x_ext + 11'(BOX_SIZE)) &&
                  (v_ext >= y_ext) && (v_ext < y_ext + 11'(BOX_SIZE));

   always_comb begin
      rgb_d = rgb_q;
      if (pix_en) begin
         if (!video_on)  rgb_d = '0;
         else if (hit)   rgb_d = palette(pal_q);
         else            rgb_d = BG_COLOR;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pal_q   <= '0;
         cnt_q   <= '0;
         rgb_q   <= '0;
      end else begin
         state_q <= state_d;
         pal_q   <= pal_d;
         cnt_q   <= cnt_d;
         rgb_q   <= rgb_d;
      end
   end

   assign red        = rgb_q.r;
   assign green      = rgb_q.g;
   assign blue       = rgb_q.b;
   assign bounce_cnt = cnt_q;

endmodule

// File: tb/tb_vga_box_animator.sv
// Directed bench for vga_box_animator: three instances cover default motion,
// the right/bottom corner bounce, and a tiny arena for fast counter wrap.
module tb_vga_box_animator;

   localparam logic [8:0] P0 = 9'b111_000_000;
   localparam logic [8:0] P1 = 9'b000_111_000;
   localparam logic [8:0] BG = 9'b000_000_001;

   logic       clk = 1'b0;
   logic       rst, pix_en, video_on, freeze;
   logic       tick_a, tick_c, tick_w;
   logic [9:0] hcount, vcount;
   logic [2:0] r_a, g_a, b_a, r_c, g_c, b_c, r_w, g_w, b_w;
   logic [7:0] cnt_a, cnt_c, cnt_w;
   logic [8:0] rgb_a, rgb_c, rgb_w;
   int         errors = 0;
   int         checks = 0;

   assign rgb_a = {r_a, g_a, b_a};
   assign rgb_c = {r_c, g_c, b_c};
   assign rgb_w = {r_w, g_w, b_w};

   always #5 clk = ~clk;

   vga_box_animator dut_a (
      .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
      .video_on(video_on), .frame_tick(tick_a), .freeze(freeze),
      .red(r_a), .green(g_a), .blue(b_a), .bounce_cnt(cnt_a)
   );

   vga_box_animator #(.X0(607), .Y0(447)) dut_c (
      .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
      .video_on(video_on), .frame_tick(tick_c), .freeze(freeze),
      .red(r_c), .green(g_c), .blue(b_c), .bounce_cnt(cnt_c)
   );

   vga_box_animator #(.H_ACTIVE(33), .V_ACTIVE(33), .BOX_SIZE(32), .STEP(1)) dut_w (
      .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
      .video_on(video_on), .frame_tick(tick_w), .freeze(freeze),
      .red(r_w), .green(g_w), .blue(b_w), .bounce_cnt(cnt_w)
   );

   task automatic pixel(input int h, input int v, input logic von);
      @(negedge clk);
      hcount   = 10'(h);
      vcount   = 10'(v);
      video_on = von;
      pix_en   = 1'b1;
      @(negedge clk);
      pix_en   = 1'b0;
   endtask

   task automatic tick(input int which, input int n);
      repeat (n) begin
         @(negedge clk);
         case (which)
            0:       tick_a = 1'b1;
            1:       tick_c = 1'b1;
            default: tick_w = 1'b1;
         endcase
         @(negedge clk);
         tick_a = 1'b0;
         tick_c = 1'b0;
         tick_w = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (rgb_a !== 9'd0) begin errors++; $display("FAIL rst_rgb got=%b exp=%b", rgb_a, 9'd0); end
      checks++; if (dut_a.u_x.pos_q !== 10'd0 || dut_a.u_y.pos_q !== 10'd0) begin errors++; $display("FAIL rst_xy got=%0d,%0d exp=0,0", dut_a.u_x.pos_q, dut_a.u_y.pos_q); end
      checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", cnt_a); end
      checks++; if (dut_c.u_x.pos_q !== 10'd607 || dut_c.u_y.pos_q !== 10'd447) begin errors++; $display("FAIL rst_xy0 got=%0d,%0d exp=607,447", dut_c.u_x.pos_q, dut_c.u_y.pos_q); end
      rst = 1'b0;
      pixel(5, 5, 1'b1);
      checks++; if (rgb_a !== P0) begin errors++; $display("FAIL px_5_5 got=%b exp=%b", rgb_a, P0); end
      pixel(40, 5, 1'b1);
      checks++; if (rgb_a !== BG) begin errors++; $display("FAIL px_40_5 got=%b exp=%b", rgb_a, BG); end
      hcount = 10'd5;
      repeat (3) @(negedge clk);
      checks++; if (rgb_a !== BG) begin errors++; $display("FAIL hold_no_pix_en got=%b exp=%b", rgb_a, BG); end
   endtask

   task automatic test_motion;
      tick(0, 10);
      checks++; if (dut_a.u_x.pos_q !== 10'd20 || dut_a.u_y.pos_q !== 10'd20) begin errors++; $display("FAIL motion_xy got=%0d,%0d exp=20,20", dut_a.u_x.pos_q, dut_a.u_y.pos_q); end
      checks++; if (dut_a.pal_q !== 3'd0 || cnt_a !== 8'd0) begin errors++; $display("FAIL motion_pal got=%0d cnt=%0d exp=0,0", dut_a.pal_q, cnt_a); end
      pixel(51, 51, 1'b1);
      checks++; if (rgb_a !== P0) begin errors++; $display("FAIL px_51_51 got=%b exp=%b", rgb_a, P0); end
      pixel(52, 52, 1'b1);
      checks++; if (rgb_a !== BG) begin errors++; $display("FAIL px_52_52 got=%b exp=%b", rgb_a, BG); end
      pixel(19, 30, 1'b1);
      checks++; if (rgb_a !== BG) begin errors++; $display("FAIL px_19_30 got=%b exp=%b", rgb_a, BG); end
   endtask

   task automatic test_freeze;
      freeze = 1'b1;
      tick(0, 5);
      freeze = 1'b0;
      checks++; if (dut_a.u_x.pos_q !== 10'd20 || dut_a.u_y.pos_q !== 10'd20 || dut_a.u_x.dir_q !== 1'b1) begin errors++; $display("FAIL freeze_xy got=%0d,%0d exp=20,20", dut_a.u_x.pos_q, dut_a.u_y.pos_q); end
      pixel(30, 30, 1'b0);
      checks++; if (rgb_a !== 9'd0) begin errors++; $display("FAIL blank_rgb got=%b exp=%b", rgb_a, 9'd0); end
   endtask

   task automatic test_simultaneous;
      // pixel (20,20) is inside only for the pre-update x/y
      @(negedge clk);
      hcount = 10'd20; vcount = 10'd20; video_on = 1'b1;
      pix_en = 1'b1; tick_a = 1'b1;
      @(negedge clk);
      pix_en = 1'b0; tick_a = 1'b0;
      checks++; if (rgb_a !== P0) begin errors++; $display("FAIL same_cycle_rgb got=%b exp=%b", rgb_a, P0); end
      checks++; if (dut_a.u_x.pos_q !== 10'd22) begin errors++; $display("FAIL same_cycle_x got=%0d exp=22", dut_a.u_x.pos_q); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      tick_a = 1'b1;
      @(negedge clk);
      @(negedge clk);
      tick_a = 1'b0;
      @(negedge clk);
      checks++; if (dut_a.u_x.pos_q !== 10'd24) begin errors++; $display("FAIL held_tick_x got=%0d exp=24", dut_a.u_x.pos_q); end
      tick(0, 1);
      checks++; if (dut_a.u_x.pos_q !== 10'd26) begin errors++; $display("FAIL next_tick_x got=%0d exp=26", dut_a.u_x.pos_q); end
   endtask

   task automatic test_corner;
      tick(1, 1);
      checks++; if (dut_c.u_x.pos_q !== 10'd608 || dut_c.u_y.pos_q !== 10'd448) begin errors++; $display("FAIL corner_xy got=%0d,%0d exp=608,448", dut_c.u_x.pos_q, dut_c.u_y.pos_q); end
      checks++; if (dut_c.u_x.dir_q !== 1'b0 || dut_c.u_y.dir_q !== 1'b0) begin errors++; $display("FAIL corner_dir got=%b%b exp=00", dut_c.u_x.dir_q, dut_c.u_y.dir_q); end
      checks++; if (cnt_c !== 8'd1 || dut_c.pal_q !== 3'd1) begin errors++; $display("FAIL corner_cnt got=%0d pal=%0d exp=1,1", cnt_c, dut_c.pal_q); end
      pixel(608, 448, 1'b1);
      checks++; if (rgb_c !== P1) begin errors++; $display("FAIL corner_px_in got=%b exp=%b", rgb_c, P1); end
      pixel(607, 448, 1'b1);
      checks++; if (rgb_c !== BG) begin errors++; $display("FAIL corner_px_out got=%b exp=%b", rgb_c, BG); end
      tick(1, 1);
      checks++; if (dut_c.u_x.pos_q !== 10'd606 || dut_c.u_y.pos_q !== 10'd446 || cnt_c !== 8'd1) begin errors++; $display("FAIL retreat got=%0d,%0d cnt=%0d exp=606,446,1", dut_c.u_x.pos_q, dut_c.u_y.pos_q, cnt_c); end
   endtask

   task automatic test_wrap;
      // 33-wide arena, step 1: a bounce on every second tick
      tick(2, 14);
      checks++; if (dut_w.pal_q !== 3'd7 || cnt_w !== 8'd7) begin errors++; $display("FAIL wrap_7 got pal=%0d cnt=%0d exp=7,7", dut_w.pal_q, cnt_w); end
      tick(2, 2);
      checks++; if (dut_w.pal_q !== 3'd0 || cnt_w !== 8'd8) begin errors++; $display("FAIL pal_wrap got pal=%0d cnt=%0d exp=0,8", dut_w.pal_q, cnt_w); end
      tick(2, 494);
      checks++; if (cnt_w !== 8'd255) begin errors++; $display("FAIL cnt_255 got=%0d exp=255", cnt_w); end
      tick(2, 2);
      checks++; if (cnt_w !== 8'd0 || dut_w.pal_q !== 3'd0) begin errors++; $display("FAIL cnt_wrap got cnt=%0d pal=%0d exp=0,0", cnt_w, dut_w.pal_q); end
   endtask

   task automatic test_async_reset;
      pixel(100, 100, 1'b1);
      checks++; if (rgb_a !== BG) begin errors++; $display("FAIL pre_rst_rgb got=%b exp=%b", rgb_a, BG); end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (rgb_a !== 9'd0 || rgb_c !== 9'd0 || rgb_w !== 9'd0) begin errors++; $display("FAIL async_rgb got=%b,%b,%b exp=0", rgb_a, rgb_c, rgb_w); end
      checks++; if (dut_a.u_x.pos_q !== 10'd0 || dut_a.u_y.pos_q !== 10'd0) begin errors++; $display("FAIL async_xy got=%0d,%0d exp=0,0", dut_a.u_x.pos_q, dut_a.u_y.pos_q); end
      checks++; if (cnt_c !== 8'd0 || dut_c.u_x.pos_q !== 10'd607) begin errors++; $display("FAIL async_c got cnt=%0d x=%0d exp=0,607", cnt_c, dut_c.u_x.pos_q); end
      @(negedge clk);
      rst = 1'b0;
      pixel(5, 5, 1'b1);
      checks++; if (rgb_a !== P0) begin errors++; $display("FAIL post_rst_px got=%b exp=%b", rgb_a, P0); end
   endtask

   initial begin
      pix_en = 1'b0; video_on = 1'b0; freeze = 1'b0;
      tick_a = 1'b0; tick_c = 1'b0; tick_w = 1'b0;
      hcount = '0; vcount = '0;
      test_reset();
      test_motion();
      test_freeze();
      test_simultaneous();
      test_back_to_back();
      test_corner();
      test_wrap();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
